// File: rtl/bin_to_bcd2.sv
// bin_to_bcd2: sequential shift-and-add-3 converter from binary to two-digit packed BCD
module bin_to_bcd2 #(
    parameter int BIN_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin_in,
    output logic             busy,
    output logic             done,
    output logic [7:0]       bcd_out,
    output logic             ovf
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state;
    logic [BIN_W-1:0] sr;
    logic [11:0] scratch, adj;
    logic [11+BIN_W:0] sh;
    logic [3:0] cnt;
    logic oor;
    // add 3 to every nibble >= 5; nibbles never exceed 9 here, so no carry crosses nibbles
    always_comb begin
        adj = scratch;
        for (int i = 0; i < 3; i++)
            adj[4*i +: 4] = (scratch[4*i +: 4] >= 4'd5) ? scratch[4*i +: 4] + 4'd3 : scratch[4*i +: 4];
    end
    assign sh = {adj, sr} << 1;
    // control FSM with registered handshake outputs; the result register only moves on the done edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd_out <= 8'h00;
            ovf     <= 1'b0;
            sr      <= '0;
            scratch <= '0;
            cnt     <= '0;
            oor     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state   <= SHIFT;
                        busy    <= 1'b1;
                        sr      <= bin_in;
                        scratch <= '0;
                        cnt     <= 4'(BIN_W);
                        oor     <= 32'(bin_in) > 32'd99;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    scratch <= sh[11+BIN_W:BIN_W];
                    sr      <= sh[BIN_W-1:0];
                    cnt     <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        bcd_out <= oor ? 8'hFF : sh[BIN_W+7:BIN_W];
                        ovf     <= oor;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bin_to_bcd2.sv
// tb_bin_to_bcd2: randomized and directed checks of bin_to_bcd2 against an arithmetic model
module tb_bin_to_bcd2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start7 = 1'b0, start8 = 1'b0;
    logic [6:0] bin7 = '0;
    logic [7:0] bin8 = '0;
    logic busy7, done7, ovf7, busy8, done8, ovf8;
    logic [7:0] bcd7, bcd8;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bin_to_bcd2 #(.BIN_W(7)) u7 (
        .clk(clk), .rst(rst), .start(start7), .bin_in(bin7),
        .busy(busy7), .done(done7), .bcd_out(bcd7), .ovf(ovf7)
    );
    bin_to_bcd2 #(.BIN_W(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .bin_in(bin8),
        .busy(busy8), .done(done8), .bcd_out(bcd8), .ovf(ovf8)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_bcd(input int v);
        return v > 99 ? 8'hFF : 8'((v / 10) * 16 + v % 10);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one conversion on the selected instance; reports latency and busy cycles, then checks the result
    task automatic run(input int sel, input int v, input int exp_lat);
        int lat, busyc;
        if (sel == 8) begin start8 = 1'b1; bin8 = 8'(v); end
        else begin start7 = 1'b1; bin7 = 7'(v); end
        tick();
        start7 = 1'b0;
        start8 = 1'b0;
        lat = 0;
        busyc = 0;
        while (!(sel == 8 ? done8 : done7) && lat < 30) begin
            if (sel == 8 ? busy8 : busy7) busyc++;
            tick();
            lat++;
        end
        chk($sformatf("lat%0d_%0d", sel, v), lat, exp_lat);
        chk($sformatf("busy%0d_%0d", sel, v), busyc, exp_lat);
        chk($sformatf("bcd%0d_%0d", sel, v), sel == 8 ? bcd8 : bcd7, exp_bcd(v));
        chk($sformatf("ovf%0d_%0d", sel, v), sel == 8 ? ovf8 : ovf7, v > 99);
        tick();
        chk($sformatf("donepulse%0d_%0d", sel, v), sel == 8 ? done8 : done7, 0);
    endtask

    initial begin
        int cnt, dn;
        logic [7:0] seen;
        int bounds[6] = '{0, 9, 10, 99, 100, 127};
        tick();
        tick();
        chk("rst_bcd", bcd7, 8'h00);
        chk("rst_busy", busy7, 0);
        chk("rst_done", done7, 0);
        chk("rst_ovf", ovf7, 0);
        rst = 1'b0;
        tick();
        run(7, 42, 7);
        repeat (20) tick();
        chk("hold42", bcd7, 8'h42);
        foreach (bounds[i]) run(7, bounds[i], 7);
        repeat (30) run(7, int'($urandom_range(0, 127)), 7);
        // start held high: one result per 8 cycles
        start7 = 1'b1;
        bin7 = 7'd0;
        tick();
        for (int v = 0; v < 128; v++) begin
            cnt = 0;
            while (!done7 && cnt < 20) begin tick(); cnt++; end
            chk($sformatf("b2b_gap_%0d", v), cnt, 7);
            chk($sformatf("b2b_bcd_%0d", v), bcd7, exp_bcd(v));
            chk($sformatf("b2b_ovf_%0d", v), ovf7, v > 99);
            bin7 = 7'(v + 1);
            tick();
        end
        start7 = 1'b0;
        repeat (10) tick();
        // start and bin_in changes during SHIFT are ignored
        start7 = 1'b1;
        bin7 = 7'd57;
        tick();
        start7 = 1'b0;
        tick();
        tick();
        bin7 = 7'd13;
        start7 = 1'b1;
        tick();
        start7 = 1'b0;
        dn = 0;
        seen = 8'h00;
        repeat (15) begin
            if (done7) begin dn++; seen = bcd7; end
            tick();
        end
        chk("ignore_dones", dn, 1);
        chk("ignore_bcd", seen, 8'h57);
        // asynchronous reset mid-conversion
        start7 = 1'b1;
        bin7 = 7'd88;
        tick();
        start7 = 1'b0;
        tick();
        tick();
        chk("pre_rst_busy", busy7, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", busy7, 0);
        chk("arst_done", done7, 0);
        chk("arst_ovf", ovf7, 0);
        chk("arst_bcd", bcd7, 8'h00);
        tick();
        rst = 1'b0;
        dn = 0;
        repeat (15) begin
            if (done7) dn++;
            tick();
        end
        chk("arst_nodone", dn, 0);
        run(7, 31, 7);
        // wider instance
        run(8, 255, 8);
        run(8, 99, 8);
        repeat (20) run(8, int'($urandom_range(0, 255)), 8);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
